// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single word-addressed memory slot per cycle between the fetch
// requester and the execute-stage data requester. Data requests can be single
// loads/stores or two-beat pairs (addr, addr+1); the second beat of a pair is
// issued from latched state while the arbiter reports busy. Read data returns
// one cycle after issue and is steered to its owner by a registered tag. A
// starvation counter lets fetch win once it has been denied STARVE_MAX times.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   f_req/f_addr/f_gnt         fetch read request, address, accept
//   f_rvalid/f_rdata           fetch read return
//   d_req/d_we/d_pair/d_addr   data request, store flag, pair flag, address
//   d_wdata0/d_wdata1          store data for beat 0 / beat 1
//   d_gnt                      data request accepted (beat 0 issued)
//   d_rvalid/d_rbeat/d_rdata   data read return and its beat index
//   d_done                     data transaction fully complete (pulse)
//   busy                       second pair beat in progress
//   mem_raddr/mem_rdata        memory read port (1-cycle latency)
//   mem_wen/mem_waddr/mem_wdata memory write port

module mem_port_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_pair,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata0,
    input  logic [DW-1:0] d_wdata1,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_rbeat,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          busy,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE,
        BEAT1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] starve;
    logic          starve_hit;

    // Latched second beat of a pair
    logic [AW-1:0] b1_addr;
    logic          b1_we;
    logic [DW-1:0] b1_wdata;

    // Read-return tag: valid, owner (1 = data), beat index, last beat of txn
    logic          rd_valid;
    logic          rd_owner;
    logic          rd_beat;
    logic          rd_last;
    logic          st_done;

    logic          grant_f;
    logic          grant_d;
    logic          rd_issue;
    logic          rd_to_data;
    logic          rd_last_next;
    logic          st_done_next;

    assign starve_hit = (starve == SW'(STARVE_MAX));

    // Arbitration, address/data muxing and next state. Grants and the write
    // strobe are suppressed while reset is asserted so nothing reaches memory.
    always_comb begin
        state_next   = state;
        grant_f      = 1'b0;
        grant_d      = 1'b0;
        busy         = 1'b0;
        mem_raddr    = f_addr;
        mem_wen      = 1'b0;
        mem_waddr    = d_addr;
        mem_wdata    = d_wdata0;
        rd_issue     = 1'b0;
        rd_to_data   = 1'b0;
        rd_last_next = 1'b0;
        st_done_next = 1'b0;

        case (state)
            IDLE: begin
                // Data normally wins; fetch wins once starved, data still
                // takes an idle slot when fetch is not asking.
                if (d_req && (!starve_hit || !f_req)) begin
                    grant_d = 1'b1;
                end else if (f_req) begin
                    grant_f = 1'b1;
                end

                if (grant_f) begin
                    mem_raddr = f_addr;
                    rd_issue  = 1'b1;
                end

                if (grant_d) begin
                    if (d_we) begin
                        mem_wen      = 1'b1;
                        st_done_next = !d_pair;
                    end else begin
                        mem_raddr    = d_addr;
                        rd_issue     = 1'b1;
                        rd_to_data   = 1'b1;
                        rd_last_next = !d_pair;
                    end
                    if (d_pair) begin
                        state_next = BEAT1;
                    end
                end
            end

            BEAT1: begin
                busy      = 1'b1;
                mem_raddr = b1_addr;
                mem_waddr = b1_addr;
                mem_wdata = b1_wdata;
                if (b1_we) begin
                    mem_wen      = 1'b1;
                    st_done_next = 1'b1;
                end else begin
                    rd_issue     = 1'b1;
                    rd_to_data   = 1'b1;
                    rd_last_next = 1'b1;
                end
                state_next = IDLE;
            end
        endcase

        if (!rst_n) begin
            grant_f      = 1'b0;
            grant_d      = 1'b0;
            mem_wen      = 1'b0;
            rd_issue     = 1'b0;
            st_done_next = 1'b0;
        end
    end

    assign f_gnt = grant_f;
    assign d_gnt = grant_d;

    // State register and starvation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state <= state_next;
            if (!f_req || grant_f) begin
                starve <= '0;
            end else if (!starve_hit) begin
                starve <= starve + SW'(1);
            end
        end
    end

    // Capture the second beat of a pair at grant time; address wraps mod 2^AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_addr  <= '0;
            b1_we    <= 1'b0;
            b1_wdata <= '0;
        end else if (grant_d && d_pair) begin
            b1_addr  <= d_addr + AW'(1);
            b1_we    <= d_we;
            b1_wdata <= d_wdata1;
        end
    end

    // Read-return tag and store-completion pulse, one cycle behind issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_owner <= 1'b0;
            rd_beat  <= 1'b0;
            rd_last  <= 1'b0;
            st_done  <= 1'b0;
        end else begin
            rd_valid <= rd_issue;
            rd_owner <= rd_to_data;
            rd_beat  <= (state == BEAT1);
            rd_last  <= rd_last_next;
            st_done  <= st_done_next;
        end
    end

    assign f_rvalid = rd_valid && !rd_owner;
    assign d_rvalid = rd_valid && rd_owner;
    assign d_rbeat  = d_rvalid && rd_beat;
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign d_done   = st_done || (d_rvalid && rd_last);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. A small memory model returns fixed
// preloaded words one cycle after the read address; each scenario task drives
// inputs just after the rising edge and compares outputs on the falling edge
// against hand-computed values.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req;
    logic [14:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic        d_pair;
    logic [14:0] d_addr;
    logic [15:0] d_wdata0;
    logic [15:0] d_wdata1;
    logic        d_gnt;
    logic        d_rvalid;
    logic        d_rbeat;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        busy;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        mem_wen;
    logic [14:0] mem_waddr;
    logic [15:0] mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;
    int wr51_count = 0;

    mem_port_arbiter #(
        .AW(15),
        .DW(16),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_gnt(f_gnt),
        .f_rvalid(f_rvalid),
        .f_rdata(f_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_pair(d_pair),
        .d_addr(d_addr),
        .d_wdata0(d_wdata0),
        .d_wdata1(d_wdata1),
        .d_gnt(d_gnt),
        .d_rvalid(d_rvalid),
        .d_rbeat(d_rbeat),
        .d_rdata(d_rdata),
        .d_done(d_done),
        .busy(busy),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .mem_wen(mem_wen),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    // Preloaded memory contents used by the scenarios
    function automatic logic [15:0] mem_word(input logic [14:0] a);
        case (a)
            15'h0010: mem_word = 16'hABCD;
            15'h0020: mem_word = 16'h1234;
            15'h7FFF: mem_word = 16'h1111;
            15'h0000: mem_word = 16'h2222;
            default:  mem_word = 16'h0000;
        endcase
    endfunction

    // Registered read port plus a tally of writes to the aborted beat address
    always @(posedge clk) begin
        mem_rdata <= mem_word(mem_raddr);
        if (mem_wen && mem_waddr == 15'h0051) wr51_count <= wr51_count + 1;
    end

    // Hard bound on simulation time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        f_req    = 1'b0;
        f_addr   = 15'h0000;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_pair   = 1'b0;
        d_addr   = 15'h0000;
        d_wdata0 = 16'h0000;
        d_wdata1 = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        f_req    = 1'b1;
        f_addr   = 15'h0010;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_pair   = 1'b1;
        d_addr   = 15'h0040;
        d_wdata0 = 16'h00AA;
        d_wdata1 = 16'h00BB;
        @(negedge clk);
        n_cmp++; if (f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_f_gnt: got %b expected 0", f_gnt); end
        n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_d_gnt: got %b expected 0", d_gnt); end
        n_cmp++; if (mem_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mem_wen: got %b expected 0", mem_wen); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if ({f_rvalid, d_rvalid, d_rbeat, d_done} !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_returns: got %b expected 0000", {f_rvalid, d_rvalid, d_rbeat, d_done}); end
        step();
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        f_req  = 1'b1;
        f_addr = 15'h0010;
        @(negedge clk);
        n_cmp++; if (f_gnt !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_gnt: got %b expected 1", f_gnt); end
        n_cmp++; if (mem_raddr !== 15'h0010) begin n_bad++; $display("[TB] FAIL fetch_raddr: got %h expected 0010", mem_raddr); end
        step();
        f_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_rvalid: got f=%b d=%b expected f=1 d=0", f_rvalid, d_rvalid); end
        n_cmp++; if (f_rdata !== 16'hABCD) begin n_bad++; $display("[TB] FAIL fetch_rdata: got %h expected ABCD", f_rdata); end
    endtask

    task automatic test_priority();
        step();
        f_req  = 1'b1;
        f_addr = 15'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_pair = 1'b0;
        d_addr = 15'h0020;
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_gnt: got d=%b f=%b expected d=1 f=0", d_gnt, f_gnt); end
        n_cmp++; if (mem_raddr !== 15'h0020 || mem_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_raddr: got %h wen=%b expected 0020 wen=0", mem_raddr, mem_wen); end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || d_rbeat !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_dret: got v=%b %h beat=%b expected v=1 1234 beat=0", d_rvalid, d_rdata, d_rbeat); end
        n_cmp++; if (d_done !== 1'b1) begin n_bad++; $display("[TB] FAIL prio_done: got %b expected 1", d_done); end
        n_cmp++; if (f_gnt !== 1'b1 || f_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_fgnt: got gnt=%b rv=%b expected gnt=1 rv=0", f_gnt, f_rvalid); end
        step();
        f_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (f_rvalid !== 1'b1 || f_rdata !== 16'hABCD) begin n_bad++; $display("[TB] FAIL prio_fret: got v=%b %h expected v=1 ABCD", f_rvalid, f_rdata); end
    endtask

    task automatic test_pair_load();
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_pair = 1'b1;
        d_addr = 15'h7FFF;
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || mem_raddr !== 15'h7FFF || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL pairld_b0: got gnt=%b %h busy=%b expected gnt=1 7FFF busy=0", d_gnt, mem_raddr, busy); end
        step();
        // A new single load is presented during BEAT1 and must wait
        d_pair = 1'b0;
        d_addr = 15'h0020;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || d_gnt !== 1'b0 || mem_raddr !== 15'h0000) begin n_bad++; $display("[TB] FAIL pairld_b1: got busy=%b gnt=%b %h expected busy=1 gnt=0 0000", busy, d_gnt, mem_raddr); end
        n_cmp++; if (d_rvalid !== 1'b1 || d_rbeat !== 1'b0 || d_rdata !== 16'h1111 || d_done !== 1'b0) begin n_bad++; $display("[TB] FAIL pairld_ret0: got v=%b beat=%b %h done=%b expected v=1 beat=0 1111 done=0", d_rvalid, d_rbeat, d_rdata, d_done); end
        step();
        @(negedge clk);
        n_cmp++; if (d_rvalid !== 1'b1 || d_rbeat !== 1'b1 || d_rdata !== 16'h2222 || d_done !== 1'b1) begin n_bad++; $display("[TB] FAIL pairld_ret1: got v=%b beat=%b %h done=%b expected v=1 beat=1 2222 done=1", d_rvalid, d_rbeat, d_rdata, d_done); end
        n_cmp++; if (d_gnt !== 1'b1 || busy !== 1'b0 || mem_raddr !== 15'h0020) begin n_bad++; $display("[TB] FAIL b2b_gnt: got gnt=%b busy=%b %h expected gnt=1 busy=0 0020", d_gnt, busy, mem_raddr); end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (d_rvalid !== 1'b1 || d_rbeat !== 1'b0 || d_rdata !== 16'h1234 || d_done !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_ret: got v=%b beat=%b %h done=%b expected v=1 beat=0 1234 done=1", d_rvalid, d_rbeat, d_rdata, d_done); end
    endtask

    task automatic test_pair_store();
        step();
        f_req    = 1'b1;
        f_addr   = 15'h0010;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_pair   = 1'b1;
        d_addr   = 15'h0040;
        d_wdata0 = 16'h00AA;
        d_wdata1 = 16'h00BB;
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL pairst_gnt: got d=%b f=%b expected d=1 f=0", d_gnt, f_gnt); end
        n_cmp++; if (mem_wen !== 1'b1 || mem_waddr !== 15'h0040 || mem_wdata !== 16'h00AA) begin n_bad++; $display("[TB] FAIL pairst_w0: got wen=%b %h %h expected wen=1 0040 00AA", mem_wen, mem_waddr, mem_wdata); end
        step();
        // Inputs after grant are ignored; scramble them to prove beat 1 is latched
        d_req    = 1'b0;
        d_addr   = 15'h1234;
        d_wdata1 = 16'hFFFF;
        @(negedge clk);
        n_cmp++; if (mem_wen !== 1'b1 || mem_waddr !== 15'h0041 || mem_wdata !== 16'h00BB) begin n_bad++; $display("[TB] FAIL pairst_w1: got wen=%b %h %h expected wen=1 0041 00BB", mem_wen, mem_waddr, mem_wdata); end
        n_cmp++; if (f_gnt !== 1'b0 || busy !== 1'b1 || d_done !== 1'b0) begin n_bad++; $display("[TB] FAIL pairst_b1: got fgnt=%b busy=%b done=%b expected 0 1 0", f_gnt, busy, d_done); end
        step();
        @(negedge clk);
        n_cmp++; if (d_done !== 1'b1 || mem_wen !== 1'b0) begin n_bad++; $display("[TB] FAIL pairst_done: got done=%b wen=%b expected done=1 wen=0", d_done, mem_wen); end
        n_cmp++; if (f_gnt !== 1'b1 || mem_raddr !== 15'h0010) begin n_bad++; $display("[TB] FAIL pairst_fgnt: got %b %h expected 1 0010", f_gnt, mem_raddr); end
        step();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (f_rvalid !== 1'b1 || f_rdata !== 16'hABCD || d_done !== 1'b0) begin n_bad++; $display("[TB] FAIL pairst_fret: got v=%b %h done=%b expected v=1 ABCD done=0", f_rvalid, f_rdata, d_done); end
    endtask

    task automatic test_starvation();
        step();
        f_req  = 1'b1;
        f_addr = 15'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_pair = 1'b0;
        d_addr = 15'h0020;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL starve_dwin%0d: got d=%b f=%b expected d=1 f=0", i, d_gnt, f_gnt); end
            step();
        end
        @(negedge clk);
        n_cmp++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_raddr !== 15'h0010) begin n_bad++; $display("[TB] FAIL starve_fwin: got f=%b d=%b %h expected f=1 d=0 0010", f_gnt, d_gnt, mem_raddr); end
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234) begin n_bad++; $display("[TB] FAIL starve_dret: got v=%b %h expected v=1 1234", d_rvalid, d_rdata); end
        step();
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL starve_resume: got d=%b f=%b expected d=1 f=0", d_gnt, f_gnt); end
        n_cmp++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0 || f_rdata !== 16'hABCD) begin n_bad++; $display("[TB] FAIL starve_fret: got fv=%b dv=%b %h expected fv=1 dv=0 ABCD", f_rvalid, d_rvalid, f_rdata); end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid_pair();
        // Three data loads with fetch waiting push the counter to 3
        step();
        f_req  = 1'b1;
        f_addr = 15'h0010;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_pair = 1'b0;
        d_addr = 15'h0020;
        step();
        step();
        step();
        // Pair store granted at counter 3, counter then reaches 4
        d_we     = 1'b1;
        d_pair   = 1'b1;
        d_addr   = 15'h0050;
        d_wdata0 = 16'h0055;
        d_wdata1 = 16'h0066;
        @(negedge clk);
        n_cmp++; if (d_gnt !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 15'h0050) begin n_bad++; $display("[TB] FAIL abort_w0: got gnt=%b wen=%b %h expected 1 1 0050", d_gnt, mem_wen, mem_waddr); end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || mem_waddr !== 15'h0051) begin n_bad++; $display("[TB] FAIL abort_b1: got busy=%b %h expected busy=1 0051", busy, mem_waddr); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_wen !== 1'b0 || busy !== 1'b0 || f_gnt !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_now: got wen=%b busy=%b fgnt=%b expected 0 0 0", mem_wen, busy, f_gnt); end
        step();
        @(negedge clk);
        n_cmp++; if (d_done !== 1'b0 || d_rvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_nodone: got done=%b rv=%b expected 0 0", d_done, d_rvalid); end
        step();
        rst_n    = 1'b1;
        d_req    = 1'b1;
        d_we     = 1'b0;
        d_pair   = 1'b0;
        d_addr   = 15'h0020;
        @(negedge clk);
        // Counter was cleared, so data wins despite fetch waiting
        n_cmp++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || busy !== 1'b0 || d_done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_rearb: got d=%b f=%b busy=%b done=%b expected 1 0 0 0", d_gnt, f_gnt, busy, d_done); end
        step();
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || d_done !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_ret: got v=%b %h done=%b expected 1 1234 1", d_rvalid, d_rdata, d_done); end
        n_cmp++; if (wr51_count !== 0) begin n_bad++; $display("[TB] FAIL abort_nowrite: got %0d writes expected 0", wr51_count); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_pair_load();
        test_pair_store();
        test_starvation();
        test_reset_mid_pair();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
